// File: rtl/nand_scan_pkg.sv
// Shared constants for the NAND-only function scanner: state encoding,
// operation codes and result-width helpers.
package nand_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [1:0] OP_ANDN = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // err_count must hold 2^(2W); ones_cnt must hold W*2^(2W).
  function automatic int err_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int ones_w(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/nand_bitwise_unit.sv
// W-bit bitwise ANDN/AND/OR/XOR unit built only from 2-input NAND gates,
// including the operation multiplexer.
module nand_bitwise_unit #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  logic op0_n, op1_n;

  nand g_op0_n (op0_n, op[0], op[0]);
  nand g_op1_n (op1_n, op[1], op[1]);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic a_n, b_n, ab_n, andn_n;
    logic f_andn, f_and, f_or, x1, x2, f_xor;
    logic m0a, m0b, m0, m1a, m1b, m1, ya, yb;

    nand g_a_n  (a_n, a[i], a[i]);
    nand g_b_n  (b_n, b[i], b[i]);
    nand g_ab_n (ab_n, a[i], b[i]);

    nand g_andn_n (andn_n, a_n, b[i]);
    nand g_andn   (f_andn, andn_n, andn_n);
    nand g_and    (f_and, ab_n, ab_n);
    nand g_or     (f_or, a_n, b_n);
    nand g_x1     (x1, a[i], ab_n);
    nand g_x2     (x2, b[i], ab_n);
    nand g_xor    (f_xor, x1, x2);

    // Two-level NAND mux tree: op[0] picks within {ANDN,AND} and {OR,XOR},
    // op[1] then picks between the two pairs.
    nand g_m0a (m0a, f_andn, op0_n);
    nand g_m0b (m0b, f_and, op[0]);
    nand g_m0  (m0, m0a, m0b);
    nand g_m1a (m1a, f_or, op0_n);
    nand g_m1b (m1b, f_xor, op[0]);
    nand g_m1  (m1, m1a, m1b);
    nand g_ya  (ya, m0, op1_n);
    nand g_yb  (yb, m1, op[1]);
    nand g_y   (y[i], ya, yb);
  end

endmodule

// File: rtl/nand_func_scanner.sv
// Sweeps every (a, b) operand pair, compares the NAND-only datapath against a
// behavioural reference and reports error count, first failure and ones count.
module nand_func_scanner
  import nand_scan_pkg::*;
#(
  parameter int W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 flt_inj,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [err_w(W)-1:0]  err_count,
  output logic [W-1:0]         first_err_a,
  output logic [W-1:0]         first_err_b,
  output logic [ones_w(W)-1:0] ones_cnt
);

  localparam int EW = err_w(W);
  localparam int OW = ones_w(W);
  localparam int IW = 2 * W;

  state_t        state;
  logic [IW-1:0] idx;
  logic [1:0]    op_q;
  logic          flt_q;
  logic [W-1:0]  a, b, n_raw, n, r;
  logic [OW-1:0] pop;

  assign a = idx[IW-1:W];
  assign b = idx[W-1:0];

  nand_bitwise_unit #(.W(W)) u_nand (
    .a  (a),
    .b  (b),
    .op (op_q),
    .y  (n_raw)
  );

  assign n = n_raw ^ W'(flt_q);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    r = '0;
    case (op_q)
      OP_ANDN: r = ~a & b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + OW'(r[i]);
  end

  assign busy = (state == ST_SWEEP);
  assign done = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      op_q        <= 2'b00;
      flt_q       <= 1'b0;
      mismatch    <= 1'b0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      ones_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SWEEP;
            op_q        <= op;
            flt_q       <= flt_inj;
            idx         <= '0;
            mismatch    <= 1'b0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            ones_cnt    <= '0;
          end
        end
        ST_SWEEP: begin
          ones_cnt <= ones_cnt + pop;
          if (n != r) begin
            err_count <= err_count + EW'(1);
            mismatch  <= 1'b1;
            if (!mismatch) begin
              first_err_a <= a;
              first_err_b <= b;
            end
          end
          idx <= idx + IW'(1);
          if (idx == {IW{1'b1}}) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_func_scanner.sv
// Self-checking bench: W=2 checked every cycle against a sweep-level model,
// plus directed sweeps on W=1 and W=4 builds.
module tb_nand_func_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] starts = 3'b000;
  logic [1:0] op = 2'b00;
  logic       flt_inj = 1'b0;
  bit         cmp_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  logic       busy1, done1, mm1;
  logic [2:0] err1;
  logic [0:0] fa1, fb1;
  logic [4:0] ones1;

  logic       busy2, done2, mm2;
  logic [4:0] err2;
  logic [1:0] fa2, fb2;
  logic [6:0] ones2;

  logic        busy4, done4, mm4;
  logic [8:0]  err4;
  logic [3:0]  fa4, fb4;
  logic [10:0] ones4;

  nand_func_scanner #(.W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(starts[0]), .op(op), .flt_inj(flt_inj),
    .busy(busy1), .done(done1), .mismatch(mm1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1), .ones_cnt(ones1)
  );

  nand_func_scanner #(.W(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(starts[1]), .op(op), .flt_inj(flt_inj),
    .busy(busy2), .done(done2), .mismatch(mm2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .ones_cnt(ones2)
  );

  nand_func_scanner #(.W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(starts[2]), .op(op), .flt_inj(flt_inj),
    .busy(busy4), .done(done4), .mismatch(mm4), .err_count(err4),
    .first_err_a(fa4), .first_err_b(fb4), .ones_cnt(ones4)
  );

  typedef struct {
    int err;
    int ones;
    int fa;
    int fb;
    int mm;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-sweep result computed straight from the operation definitions.
  function automatic res_t expect_res(input int w, input int o, input bit f);
    res_t res;
    int   mask, r, n;
    res  = '{0, 0, 0, 0, 0};
    mask = (1 << w) - 1;
    for (int a = 0; a <= mask; a++) begin
      for (int b = 0; b <= mask; b++) begin
        case (o)
          0:       r = ~a & b & mask;
          1:       r = a & b;
          2:       r = a | b;
          default: r = a ^ b;
        endcase
        n = f ? (r ^ 1) : r;
        res.ones += $countones(r);
        if (n != r) begin
          res.err++;
          if (res.mm == 0) begin
            res.mm = 1;
            res.fa = a;
            res.fb = b;
          end
        end
      end
    end
    return res;
  endfunction

  // W=2 handshake model: cycles left in the sweep, done pulse, final results.
  int   m_left;
  bit   m_done;
  res_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '{0, 0, 0, 0, 0};
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (starts[1]) begin
      m_left <= 16;
      m_res  <= expect_res(2, int'(op), flt_inj);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("w2_busy", busy2, 32'(m_left > 0));
      check("w2_done", done2, 32'(m_done));
      if (m_left == 0) begin
        check("w2_err_count", err2, m_res.err);
        check("w2_mismatch", mm2, m_res.mm);
        check("w2_first_a", fa2, m_res.fa);
        check("w2_first_b", fb2, m_res.fb);
        check("w2_ones_cnt", ones2, m_res.ones);
      end
    end
  end

  // Start one sweep on the chosen build and follow it to done.
  task automatic sweep(input int which, input logic [1:0] o, input logic f,
                       input int exp_lat, input int exp_ones);
    int   lat, busy_n, act_err, act_ones, act_mm, act_fa, act_fb;
    bit   seen;
    res_t ex;
    ex     = expect_res(1 << which, int'(o), f);
    busy_n = 0;
    seen   = 1'b0;
    @(posedge clk); #1;
    op = o;
    flt_inj = f;
    starts[which] = 1'b1;
    @(posedge clk); #1;
    starts[which] = 1'b0;
    lat = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 0 && done1) || (which == 1 && done2) || (which == 2 && done4)) begin
        seen = 1'b1;
        break;
      end
      if ((which == 0 && busy1) || (which == 1 && busy2) || (which == 2 && busy4)) busy_n++;
      @(posedge clk);
      lat++;
    end
    check("done_seen", 32'(seen), 1);
    case (which)
      0:       begin act_err = err1; act_ones = ones1; act_mm = mm1; act_fa = fa1; act_fb = fb1; end
      1:       begin act_err = err2; act_ones = ones2; act_mm = mm2; act_fa = fa2; act_fb = fb2; end
      default: begin act_err = err4; act_ones = ones4; act_mm = mm4; act_fa = fa4; act_fb = fb4; end
    endcase
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_n, exp_lat - 1);
    check("ones_literal", act_ones, exp_ones);
    check("ones_model", act_ones, ex.ones);
    check("err_model", act_err, ex.err);
    check("mismatch_model", act_mm, ex.mm);
    check("first_a_model", act_fa, ex.fa);
    check("first_b_model", act_fb, ex.fb);
  endtask

  initial begin
    int lat, done_n;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_err", err2, 0);
    check("rst_ones", ones2, 0);
    check("rst_ones_w4", ones4, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ones", ones2, 0);
    check("idle_mismatch", mm2, 0);

    sweep(1, 2'b00, 1'b0, 17, 8);
    check("andn_err", err2, 0);
    sweep(1, 2'b01, 1'b0, 17, 8);
    sweep(1, 2'b10, 1'b0, 17, 24);
    sweep(1, 2'b11, 1'b0, 17, 16);
    check("xor_err", err2, 0);

    sweep(1, 2'b01, 1'b1, 17, 8);
    check("flt_mismatch", mm2, 1);
    check("flt_err", err2, 16);
    check("flt_first_a", fa2, 0);
    check("flt_first_b", fb2, 0);

    // Second start and op change mid-sweep must be ignored.
    @(posedge clk); #1;
    op = 2'b01;
    flt_inj = 1'b0;
    starts[1] = 1'b1;
    @(posedge clk); #1;
    starts[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    starts[1] = 1'b1;
    op = 2'b11;
    flt_inj = 1'b1;
    @(posedge clk); #1;
    starts[1] = 1'b0;
    op = 2'b00;
    flt_inj = 1'b0;
    lat = 6;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check("hs_done_seen", 32'(seen), 1);
    check("hs_latency", lat, 17);
    check("hs_ones", ones2, 8);
    check("hs_err", err2, 0);

    // Reset in the middle of a faulty sweep discards everything.
    @(posedge clk); #1;
    op = 2'b01;
    flt_inj = 1'b1;
    starts[1] = 1'b1;
    @(posedge clk); #1;
    starts[1] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy2, 0);
    check("abort_done", done2, 0);
    check("abort_mismatch", mm2, 0);
    check("abort_err", err2, 0);
    check("abort_first_a", fa2, 0);
    check("abort_first_b", fb2, 0);
    check("abort_ones", ones2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done2) done_n++;
    end
    check("abort_no_done", done_n, 0);

    sweep(0, 2'b10, 1'b0, 5, 3);
    check("w1_err", err1, 0);
    sweep(2, 2'b10, 1'b0, 257, 768);
    check("w4_err", err4, 0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
